// File: rtl/imm_packer_if.sv
// Request/result bundle for the immediate packer: request handshake in,
// packed instruction handshake out, plus error-counter clear and readout.
interface imm_packer_if;
  logic        i_valid;
  logic        o_ready;
  logic [31:0] i_imm;
  logic [2:0]  i_imm_src;
  logic [31:0] i_instr_base;
  logic        o_valid;
  logic        i_ready;
  logic [31:0] o_instr;
  logic        o_range_err;
  logic        i_err_clr;
  logic [15:0] o_err_count;

  modport slave (
    input  i_valid, i_imm, i_imm_src, i_instr_base, i_ready, i_err_clr,
    output o_ready, o_valid, o_instr, o_range_err, o_err_count
  );

  modport master (
    output i_valid, i_imm, i_imm_src, i_instr_base, i_ready, i_err_clr,
    input  o_ready, o_valid, o_instr, o_range_err, o_err_count
  );
endinterface

// File: rtl/imm_packer.sv
// Two-stage pipeline that scatters an immediate into the I/S/B/J/U field
// positions of a base instruction and flags immediates that do not fit.
module imm_packer #(
  parameter int CHECK_EN = 1
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  imm_packer_if.slave  bus
);

  localparam logic [2:0] SRC_I = 3'd0;
  localparam logic [2:0] SRC_S = 3'd1;
  localparam logic [2:0] SRC_B = 3'd2;
  localparam logic [2:0] SRC_J = 3'd3;
  localparam logic [2:0] SRC_U = 3'd4;

  function automatic logic [31:0] pack_imm(input logic signed [31:0] imm,
                                           input logic [2:0]         src,
                                           input logic [31:0]        base);
    logic [31:0] r;
    r = base;
    case (src)
      SRC_I: r[31:20] = imm[11:0];
      SRC_S: begin
        r[31:25] = imm[11:5];
        r[11:7]  = imm[4:0];
      end
      SRC_B: begin
        r[31]    = imm[12];
        r[7]     = imm[11];
        r[30:25] = imm[10:5];
        r[11:8]  = imm[4:1];
      end
      SRC_J: begin
        r[31]    = imm[20];
        r[19:12] = imm[19:12];
        r[20]    = imm[11];
        r[30:21] = imm[10:1];
      end
      SRC_U: r[31:12] = imm[31:12];
      default: r = base;
    endcase
    return r;
  endfunction

  // Undefined selectors always report an error, even with checking disabled.
  function automatic logic range_err(input logic signed [31:0] imm,
                                     input logic [2:0]         src);
    logic bad;
    bad = 1'b0;
    case (src)
      SRC_I, SRC_S: bad = !((&imm[31:11]) || !(|imm[31:11]));
      SRC_B:        bad = !((&imm[31:12]) || !(|imm[31:12])) || imm[0];
      SRC_J:        bad = !((&imm[31:20]) || !(|imm[31:20])) || imm[0];
      SRC_U:        bad = |imm[11:0];
      default:      bad = 1'b1;
    endcase
    if (src > SRC_U) return 1'b1;
    return (CHECK_EN != 0) && bad;
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic                vld_p1;
  logic signed [31:0]  imm_p1;
  logic [2:0]          src_p1;
  logic [31:0]         base_p1;
  logic                vld_p2;
  logic [31:0]         instr_p2;
  logic                err_p2;
  logic [15:0]         err_cnt;
  logic                ld_p1;
  logic                ld_p2;

  assign ld_p2       = !vld_p2 || bus.i_ready;
  assign ld_p1       = !vld_p1 || ld_p2;
  assign bus.o_ready = ld_p1;

  // Stage 1: capture the request on an input handshake.
  always_ff @(posedge i_clk) begin
    if (ld_p1 && bus.i_valid) begin
      imm_p1  <= bus.i_imm;
      src_p1  <= bus.i_imm_src;
      base_p1 <= bus.i_instr_base;
    end
  end

  // Stage 2: encoded instruction, error flag and the delivered-error counter.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      vld_p1   <= 1'b0;
      vld_p2   <= 1'b0;
      instr_p2 <= '0;
      err_p2   <= 1'b0;
      err_cnt  <= '0;
    end else begin
      if (ld_p1) vld_p1 <= bus.i_valid;
      if (ld_p2) vld_p2 <= vld_p1;
      if (ld_p2 && vld_p1) begin
        instr_p2 <= pack_imm(imm_p1, src_p1, base_p1);
        err_p2   <= range_err(imm_p1, src_p1);
      end
      if (bus.i_err_clr)
        err_cnt <= '0;
      else if (vld_p2 && bus.i_ready && err_p2)
        err_cnt <= sat_inc(err_cnt);
    end
  end

  assign bus.o_valid     = vld_p2;
  assign bus.o_instr     = instr_p2;
  assign bus.o_range_err = err_p2;
  assign bus.o_err_count = err_cnt;

endmodule

// File: tb/tb_imm_packer.sv
// Randomized scoreboard bench for imm_packer with a field-level reference
// model, directed latency/backpressure/counter/reset scenarios.
module tb_imm_packer;
  localparam int CHECK_EN = 1;

  typedef struct packed {
    logic [31:0] instr;
    logic        err;
  } exp_t;

  logic clk;
  logic rst_n;
  imm_packer_if bus();

  imm_packer #(.CHECK_EN(CHECK_EN)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  int   checks = 0;
  int   fails  = 0;
  int   n_out  = 0;
  exp_t q[$];
  logic [15:0] exp_cnt = 0;
  bit   held = 0;
  logic [31:0] held_instr;
  logic        held_err;
  bit   rdy_rand = 0;
  logic rdy_val  = 1'b1;
  logic clr_val  = 1'b0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic void chk(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual=0x%08h required=0x%08h", name, act, exp);
    end
  endfunction

  // Reference: ranges expressed as signed intervals, fields as concatenations.
  function automatic exp_t model(input logic [31:0] imm, input logic [2:0] src,
                                 input logic [31:0] base);
    exp_t e;
    int   s;
    bit   ok;
    s = $signed(imm);
    ok = 1'b0;
    e.instr = base;
    case (src)
      3'd0: begin
        e.instr = {imm[11:0], base[19:0]};
        ok = (s >= -2048) && (s <= 2047);
      end
      3'd1: begin
        e.instr = {imm[11:5], base[24:12], imm[4:0], base[6:0]};
        ok = (s >= -2048) && (s <= 2047);
      end
      3'd2: begin
        e.instr = {imm[12], imm[10:5], base[24:12], imm[4:1], imm[11], base[6:0]};
        ok = (s >= -4096) && (s <= 4095) && (s % 2 == 0);
      end
      3'd3: begin
        e.instr = {imm[20], imm[10:1], imm[11], imm[19:12], base[11:0]};
        ok = (s >= -(1 << 20)) && (s < (1 << 20)) && (s % 2 == 0);
      end
      3'd4: begin
        e.instr = {imm[31:12], base[11:0]};
        ok = (imm % 4096) == 0;
      end
      default: begin
        e.instr = base;
        ok = 1'b0;
      end
    endcase
    e.err = (src > 3'd4) ? 1'b1 : ((CHECK_EN != 0) && !ok);
    return e;
  endfunction

  function automatic logic [31:0] rand_imm();
    logic [31:0] r;
    case ($urandom_range(0, 3))
      0:       r = $urandom;
      1:       r = 32'($urandom_range(0, 8191)) - 32'd4096;
      2:       r = 32'($urandom_range(0, 32'h3FFFFF)) - 32'h200000;
      default: r = $urandom & 32'hFFFFF000;
    endcase
    if ($urandom_range(0, 1) == 1) r[0] = 1'b0;
    return r;
  endfunction

  // Downstream ready and counter clear are owned by this process only.
  initial begin
    bus.i_ready   = 1'b1;
    bus.i_err_clr = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      bus.i_ready   = rdy_rand ? ($urandom_range(0, 3) != 0) : rdy_val;
      bus.i_err_clr = rdy_rand ? ($urandom_range(0, 63) == 0) : clr_val;
    end
  end

  // Monitor / scoreboard, sampled on the falling edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_o_valid", 32'(bus.o_valid), 32'd0);
      chk("rst_err_count", 32'(bus.o_err_count), 32'd0);
      q.delete();
      held    = 0;
      exp_cnt = 16'd0;
    end else begin
      exp_t e;
      bit   exp_err;
      exp_err = 1'b0;
      chk("err_count", 32'(bus.o_err_count), 32'(exp_cnt));
      if (held) begin
        chk("hold_valid", 32'(bus.o_valid), 32'd1);
        chk("hold_instr", bus.o_instr, held_instr);
        chk("hold_err", 32'(bus.o_range_err), 32'(held_err));
      end
      if (bus.o_valid && bus.i_ready) begin
        if (q.size() == 0) begin
          chk("unexpected_output", bus.o_instr, 32'hDEADBEEF);
        end else begin
          e = q.pop_front();
          chk("instr", bus.o_instr, e.instr);
          chk("range_err", 32'(bus.o_range_err), 32'(e.err));
          exp_err = e.err;
        end
        n_out++;
      end
      if (bus.i_valid && bus.o_ready)
        q.push_back(model(bus.i_imm, bus.i_imm_src, bus.i_instr_base));
      held       = bus.o_valid && !bus.i_ready;
      held_instr = bus.o_instr;
      held_err   = bus.o_range_err;
      if (bus.i_err_clr)
        exp_cnt = 16'd0;
      else if (bus.o_valid && bus.i_ready && exp_err && exp_cnt != 16'hFFFF)
        exp_cnt = exp_cnt + 16'd1;
    end
  end

  task automatic issue(input logic [31:0] imm, input logic [2:0] src,
                       input logic [31:0] base);
    bit acc;
    int n;
    acc = 1'b0;
    n   = 0;
    bus.i_valid      = 1'b1;
    bus.i_imm        = imm;
    bus.i_imm_src    = src;
    bus.i_instr_base = base;
    while (!acc && n < 1000) begin
      @(negedge clk);
      acc = bus.o_ready;
      @(posedge clk);
      #1;
      n++;
    end
    chk("accept", 32'(acc), 32'd1);
    bus.i_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q.size() != 0 || bus.o_valid) && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain", 32'(q.size() == 0 && !bus.o_valid), 32'd1);
  endtask

  initial begin
    int  base_out;
    bit  seen;
    bus.i_valid      = 1'b0;
    bus.i_imm        = '0;
    bus.i_imm_src    = '0;
    bus.i_instr_base = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 32'(bus.o_ready), 32'd1);
    chk("rst_instr", bus.o_instr, 32'd0);
    chk("rst_rerr", 32'(bus.o_range_err), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    issue(32'hFFFFF800, 3'd0, 32'h00000013);
    chk("lat_not_yet", 32'(bus.o_valid), 32'd0);
    @(posedge clk);
    #1;
    chk("lat_valid", 32'(bus.o_valid), 32'd1);
    chk("i_fmt_instr", bus.o_instr, 32'h80000013);
    chk("i_fmt_err", 32'(bus.o_range_err), 32'd0);

    issue(32'hFFFFFFFC, 3'd2, 32'h00000063);
    @(posedge clk);
    #1;
    chk("b_fmt_instr", bus.o_instr, 32'hFE000EE3);
    chk("b_fmt_err", 32'(bus.o_range_err), 32'd0);

    issue(32'h12345001, 3'd4, 32'h00000037);
    issue(32'h00100000, 3'd3, 32'h0000006F);
    chk("u_fmt_upper", 32'(bus.o_instr[31:12]), 32'h12345);
    chk("u_fmt_err", 32'(bus.o_range_err), 32'd1);
    drain();
    chk("err_count_two", 32'(bus.o_err_count), 32'd2);

    issue(32'h0, 3'd5, 32'h01234567);
    @(posedge clk);
    #1;
    chk("clr_case_valid", 32'(bus.o_valid && bus.o_range_err), 32'd1);
    clr_val = 1'b1;
    @(posedge clk);
    #1;
    clr_val = 1'b0;
    #2;
    chk("clr_wins", 32'(bus.o_err_count), 32'd0);

    @(posedge clk);
    #1;
    rdy_val  = 1'b0;
    base_out = n_out;
    fork
      begin
        for (int i = 0; i < 4; i++)
          issue(rand_imm(), 3'(i % 5), $urandom);
      end
      begin
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("bp_ready_low", 32'(bus.o_ready), 32'd0);
        chk("bp_valid_high", 32'(bus.o_valid), 32'd1);
        @(posedge clk);
        rdy_val = 1'b1;
      end
    join
    drain();
    chk("bp_count", 32'(n_out - base_out), 32'd4);

    rdy_val = 1'b0;
    @(posedge clk);
    #1;
    issue(32'h00000123, 3'd0, 32'h00000013);
    issue(32'h00000456, 3'd1, 32'h00000023);
    chk("full_ready_low", 32'(bus.o_ready), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_valid", 32'(bus.o_valid), 32'd0);
    chk("async_instr", bus.o_instr, 32'd0);
    chk("async_ready", 32'(bus.o_ready), 32'd1);
    rdy_val = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      if (bus.o_valid) seen = 1'b1;
    end
    chk("no_stale", 32'(seen), 32'd0);

    rdy_rand = 1;
    for (int i = 0; i < 1500; i++) begin
      int s;
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
      s = $urandom_range(0, 15);
      issue(rand_imm(), (s < 14) ? 3'(s % 5) : 3'(5 + s % 3), $urandom);
    end
    rdy_rand = 0;
    rdy_val  = 1'b1;
    clr_val  = 1'b0;
    @(posedge clk);
    #1;
    drain();

    for (int i = 0; i < 65540; i++)
      issue($urandom, 3'd6, $urandom);
    drain();
    chk("sat_count", 32'(bus.o_err_count), 32'h0000FFFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
